// File: rtl/i2s_rx_lock_ctrl.sv
// i2s_rx_lock_ctrl: LRCK period lock/mute sequencer for an I2S receiver; error counter enabled by I2S_RX_LOCK_ERRCNT_EN
module i2s_rx_lock_ctrl #(
  parameter int LENGTH = 32,
  parameter int LOCK_FRAMES = 4,
  parameter int RST_CYCLES = 8,
  localparam int CW = $clog2(4*LENGTH)+1
) (
  input  logic          BCLK_I,
  input  logic          ARESETN_I,
  input  logic          LRCK_I,
  input  logic          MUTE_REQN_I,
  output logic          RX_RSTN_O,
  output logic          MUTEN_O,
  output logic          LOCK_O,
  output logic          ERR_O,
  output logic [CW-1:0] PERIOD_O,
  output logic [7:0]    ERR_CNT_O
);
  typedef enum logic [1:0] {S_RST, S_ACQ, S_LOCK} state_t;
  localparam logic [CW-1:0] FRAME = CW'(2*LENGTH);
  localparam logic [CW-1:0] LIMIT = CW'(4*LENGTH);
  state_t state;
  logic lrck_q1, lrck_q2, armed;
  logic [CW-1:0] cnt;
  logic [3:0] good;
  logic [7:0] hold;
  logic fall, timeout, good_frame, bad;
  assign fall = lrck_q2 & ~lrck_q1;
  assign timeout = ~fall & (cnt == LIMIT);
  assign good_frame = fall & armed & (cnt == FRAME);
  assign bad = (fall & armed & (cnt != FRAME)) | timeout;
  always_ff @(posedge BCLK_I or negedge ARESETN_I)
    if (!ARESETN_I) begin
      state <= S_RST;
      lrck_q1 <= 1'b0;
      lrck_q2 <= 1'b0;
      armed <= 1'b0;
      cnt <= '0;
      good <= '0;
      hold <= '0;
      RX_RSTN_O <= 1'b0;
      MUTEN_O <= 1'b0;
      LOCK_O <= 1'b0;
      ERR_O <= 1'b0;
      PERIOD_O <= '0;
    end else begin
      lrck_q1 <= LRCK_I;
      lrck_q2 <= lrck_q1;
      cnt <= (fall | timeout) ? CW'(1) : cnt + 1'b1;
      if (fall) PERIOD_O <= cnt;
      ERR_O <= bad;
      // the first fall after a timeout or reset hold only arms the measurement
      armed <= (state != S_RST) & (fall | (armed & ~timeout));
      case (state)
        S_RST: begin
          good <= '0;
          if (hold == 8'(RST_CYCLES-1)) begin
            hold <= '0;
            state <= S_ACQ;
            RX_RSTN_O <= 1'b1;
          end else hold <= hold + 1'b1;
        end
        S_ACQ:
          if (bad) good <= '0;
          else if (good_frame) begin
            good <= good + 1'b1;
            if (good == 4'(LOCK_FRAMES-1)) begin
              state <= S_LOCK;
              LOCK_O <= 1'b1;
              MUTEN_O <= MUTE_REQN_I;
            end
          end
        S_LOCK:
          if (bad) begin
            state <= S_RST;
            RX_RSTN_O <= 1'b0;
            MUTEN_O <= 1'b0;
            LOCK_O <= 1'b0;
            good <= '0;
            hold <= '0;
          end else if (fall) MUTEN_O <= MUTE_REQN_I;
        default: state <= S_RST;
      endcase
    end
`ifdef I2S_RX_LOCK_ERRCNT_EN
  always_ff @(posedge BCLK_I or negedge ARESETN_I)
    if (!ARESETN_I) ERR_CNT_O <= '0;
    else if (ERR_O && ERR_CNT_O != 8'hFF) ERR_CNT_O <= ERR_CNT_O + 1'b1;
`else
  assign ERR_CNT_O = 8'h00;
`endif
endmodule

// File: tb/tb_i2s_rx_lock_ctrl.sv
// tb_i2s_rx_lock_ctrl: scoreboard bench; expected output-change events are queued, a negedge monitor pops and compares them
module tb_i2s_rx_lock_ctrl;
`ifdef I2S_RX_LOCK_ERRCNT_EN
  localparam bit ERRC_EN = 1'b1;
`else
  localparam bit ERRC_EN = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0, lrck = 1'b1, mreq = 1'b1;
  logic rx_rstn, muten, lock, err;
  logic [7:0] period, errcnt;
  i2s_rx_lock_ctrl dut (
    .BCLK_I(clk), .ARESETN_I(rstn), .LRCK_I(lrck), .MUTE_REQN_I(mreq),
    .RX_RSTN_O(rx_rstn), .MUTEN_O(muten), .LOCK_O(lock), .ERR_O(err),
    .PERIOD_O(period), .ERR_CNT_O(errcnt)
  );
  always #5 clk = ~clk;
  // vec = {rx_rstn, muten, lock, err}; period -1 and gap 0 mean "not checked"
  typedef struct {
    logic [3:0] vec;
    int period;
    int gap;
  } ev_t;
  ev_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0, last_cyc = 0;
  logic [3:0] prev = 4'b0000, cur;
  ev_t e;
  int probe_seq = 0, probe_done = 0;
  string p_name;
  logic [3:0] p_mask, p_vec;
  int p_period, p_cnt;
  bit p_final;
  task automatic push(input logic [3:0] v, input int p, input int g);
    ev_t x;
    x.vec = v;
    x.period = p;
    x.gap = g;
    exp_q.push_back(x);
  endtask
  task automatic probe(input string n, input logic [3:0] m, input logic [3:0] v, input int p, input int c, input bit f);
    p_name = n;
    p_mask = m;
    p_vec = v;
    p_period = p;
    p_cnt = c;
    p_final = f;
    probe_seq++;
    @(negedge clk);
    #1;
  endtask
  task automatic frame(input int len, input int at = -1, input logic val = 1'b1, input int pat = -1, input logic pexp = 1'b0);
    lrck = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == len/2) lrck = 1'b1;
      if (i == at) mreq = val;
      if (i == pat) probe("mute_hold", 4'b0100, {1'b0, pexp, 2'b00}, -1, -1, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin : monitor
    cyc++;
    cur = {rx_rstn, muten, lock, err};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event_unexpected cyc=%0d got vec=%b period=%0d", cyc, cur, period);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e.vec || (e.period >= 0 && period !== 8'(e.period)) || (e.gap > 0 && cyc - last_cyc != e.gap)) begin
          failures++;
          $display("FAIL event cyc=%0d got vec=%b period=%0d gap=%0d expected vec=%b period=%0d gap=%0d",
                   cyc, cur, period, cyc - last_cyc, e.vec, e.period, e.gap);
        end
      end
      prev = cur;
      last_cyc = cyc;
    end
    if (probe_seq != probe_done) begin
      probe_done = probe_seq;
      checks++;
      if (p_final) begin
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL %s pending_events=%0d expected 0", p_name, exp_q.size());
        end
      end else if (((cur ^ p_vec) & p_mask) !== 4'b0000 || (p_period >= 0 && period !== 8'(p_period)) ||
                   (p_cnt >= 0 && errcnt !== 8'(p_cnt))) begin
        failures++;
        $display("FAIL %s got vec=%b period=%0d errcnt=%0d expected vec=%b mask=%b period=%0d errcnt=%0d",
                 p_name, cur, period, errcnt, p_vec, p_mask, p_period, p_cnt);
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    probe("reset_state", 4'hF, 4'h0, 0, 0, 1'b0);
    // acquisition from power-up
    push(4'b1000, -1, 0);
    push(4'b1110, 64, 314);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    fork
      for (int k = 0; k < 7; k++) frame(64);
      begin
        repeat (7) @(posedge clk);
        #1;
        probe("hold_low", 4'b1000, 4'b0000, -1, -1, 1'b0);
        @(posedge clk);
        #1;
        probe("hold_release", 4'b1000, 4'b1000, -1, -1, 1'b0);
      end
    join
    // mute request changes act only at frame starts
    push(4'b1010, -1, 192);
    push(4'b1110, -1, 64);
    frame(64, 20, 1'b0, 40, 1'b1);
    frame(64, 20, 1'b1, 40, 1'b0);
    frame(64);
    // one short frame drops lock, then relock
    push(4'b0001, 63, 191);
    push(4'b0000, -1, 1);
    push(4'b1000, -1, 7);
    push(4'b1110, 64, 312);
    frame(64);
    frame(63);
    for (int k = 0; k < 6; k++) frame(64);
    // static LRCK: repeated timeouts, then relock
    push(4'b0001, 64, 128);
    push(4'b0000, -1, 1);
    push(4'b1000, -1, 7);
    push(4'b1001, -1, 120);
    push(4'b1000, -1, 1);
    push(4'b1001, -1, 127);
    push(4'b1000, -1, 1);
    push(4'b1110, 64, 264);
    repeat (329) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) frame(64);
    probe("errcnt_pre_reset", 4'hF, 4'b1110, 64, ERRC_EN ? 4 : 0, 1'b0);
    // asynchronous reset pulse mid-frame
    push(4'b0000, 0, 156);
    push(4'b1000, -1, 8);
    push(4'b1110, 64, 284);
    lrck = 1'b0;
    repeat (30) @(posedge clk);
    #3 rstn = 1'b0;
    #1 probe("async_clear", 4'hF, 4'h0, 0, 0, 1'b0);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lrck = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) frame(64);
    probe("errcnt_after_reset", 4'hF, 4'b1110, 64, 0, 1'b0);
    // 300 short frames: error counter saturation
    push(4'b0001, 20, 148);
    push(4'b0000, -1, 1);
    push(4'b1000, -1, 7);
    push(4'b1001, 20, 32);
    push(4'b1000, -1, 1);
    for (int j = 4; j < 300; j++) begin
      push(4'b1001, 20, 19);
      push(4'b1000, -1, 1);
    end
    for (int j = 0; j < 300; j++) begin
      if (j == 150) probe("errcnt_mid", 4'b0110, 4'b0000, 20, ERRC_EN ? 148 : 0, 1'b0);
      frame(20);
    end
    repeat (10) @(posedge clk);
    #1;
    probe("errcnt_sat", 4'hF, 4'b1000, 20, ERRC_EN ? 255 : 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    probe("errcnt_held", 4'hF, 4'b1000, 20, ERRC_EN ? 255 : 0, 1'b0);
    probe("queue_drained", 4'h0, 4'h0, -1, -1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
